sobel_mac_pipe: RTL and testbench

//  Parametrised, pipelined signed multiply-accumulate engine for the Sobel datapath.
//  - Takes one (pixel, coefficient) pair per beat and multiplies it in a MUL_STAGES-deep pipeline.
//  - Sums TAPS consecutive products (one kernel window, 9 for 3x3) and emits one saturated result per window.
//  - Uses a valid/ready stream on both sides and replaces the free-running combinational multiplier per tap.

---
 rtl/sobel_mac_pipe_pkg.sv | 40 ++++
 rtl/sobel_mac_pipe_if.sv | 37 +++
 rtl/sobel_mac_pipe_mul.sv | 77 +++++++
 rtl/sobel_mac_pipe.sv | 114 +++++++++++
 tb/tb_sobel_mac_pipe.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_mac_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Shared constants and helpers for the Sobel multiply-accumulate datapath.
//   - Default operand / result widths and tap count for a 3x3 kernel.
//   - Sobel Gx / Gy coefficient tables in raster order.
//   - clog2 for elaboration-time sizing, sat_signed for range clamping.
// -----------------------------------------------------------------------------
package sobel_pkg;

  localparam int SOBEL_A_W   = 11;
  localparam int SOBEL_B_W   = 11;
  localparam int SOBEL_OUT_W = 20;
  localparam int SOBEL_TAPS  = 9;

  localparam int SOBEL_GX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int SOBEL_GY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  // Wide signed carrier used for saturation decisions; comfortably larger
  // than any accumulator this engine is configured with.
  typedef logic signed [63:0] wide_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Clamp value into the signed range of a width-bit number.
  function automatic wide_t sat_signed(input wide_t value, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/sobel_mac_pipe_if.sv
// -----------------------------------------------------------------------------
// sobel_mac_pipe_if
//   Stream bundle of the Sobel MAC engine.
//   Input side : in_valid / in_ready handshake carrying din_a, din_b.
//   Output side: out_valid / out_ready handshake carrying dout, out_ovf.
//   acc_clr    : one-cycle abort of the window in progress.
//   master = producer/consumer environment, slave = the engine.
// -----------------------------------------------------------------------------
interface sobel_mac_pipe_if
  import sobel_pkg::*;
#(
  parameter int A_W   = SOBEL_A_W,
  parameter int B_W   = SOBEL_B_W,
  parameter int OUT_W = SOBEL_OUT_W
);

  logic                    acc_clr;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [A_W-1:0]   din_a;
  logic signed [B_W-1:0]   din_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] dout;
  logic                    out_ovf;

  modport master (
    output acc_clr, in_valid, din_a, din_b, out_ready,
    input  in_ready, out_valid, dout, out_ovf
  );

  modport slave (
    input  acc_clr, in_valid, din_a, din_b, out_ready,
    output in_ready, out_valid, dout, out_ovf
  );

endinterface

// File: rtl/sobel_mac_pipe_mul.sv
// -----------------------------------------------------------------------------
// sobel_mac_mul_pipe
//   Signed A_W x B_W multiplier with MUL_STAGES register stages and a matching
//   valid shift register. Everything advances on the shared enable adv.
//   Ports: ap_clk, ap_rst, adv (advance), flush (drop all in-flight products),
//          in_fire (a tap enters this cycle), a, b (operands),
//          prod_valid / prod (full-precision product leaving the pipe).
//   With two or more stages the operands are registered first and the
//   product afterwards, which is the shape a DSP48 absorbs (A/B reg, M reg,
//   P reg). Data registers carry no reset so they can live inside the DSP.
// -----------------------------------------------------------------------------
module sobel_mac_mul_pipe
  import sobel_pkg::*;
#(
  parameter  int A_W        = SOBEL_A_W,
  parameter  int B_W        = SOBEL_B_W,
  parameter  int MUL_STAGES = 2,
  localparam int P_W        = A_W + B_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  adv,
  input  logic                  flush,
  input  logic                  in_fire,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic                  prod_valid,
  output logic signed [P_W-1:0] prod
);

  logic [MUL_STAGES-1:0] vld_reg;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || flush) begin
      vld_reg <= '0;
    end else if (adv) begin
      vld_reg[0] <= in_fire;
      for (int i = 1; i < MUL_STAGES; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

  assign prod_valid = vld_reg[MUL_STAGES-1];

  generate
    if (MUL_STAGES == 1) begin : g_one
      logic signed [P_W-1:0] p_reg;

      always_ff @(posedge ap_clk) begin
        if (adv) p_reg <= P_W'(a) * P_W'(b);
      end

      assign prod = p_reg;
    end else begin : g_multi
      logic signed [A_W-1:0] a_reg;
      logic signed [B_W-1:0] b_reg;
      logic signed [P_W-1:0] p_reg [MUL_STAGES-1];

      always_ff @(posedge ap_clk) begin
        if (adv) begin
          a_reg    <= a;
          b_reg    <= b;
          p_reg[0] <= P_W'(a_reg) * P_W'(b_reg);
        end
      end

      // Extra stages beyond the product register retime the result.
      for (genvar gi = 1; gi < MUL_STAGES - 1; gi++) begin : g_dly
        always_ff @(posedge ap_clk) begin
          if (adv) p_reg[gi] <= p_reg[gi-1];
        end
      end

      assign prod = p_reg[MUL_STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/sobel_mac_pipe.sv
// -----------------------------------------------------------------------------
// sobel_mac_pipe
//   Pipelined signed multiply-accumulate engine: one (pixel, coefficient) tap
//   per beat, TAPS consecutive products summed into one result per window,
//   result clamped (SAT=1) or wrapped (SAT=0) to OUT_W bits.
//   Ports: ap_clk, ap_rst (synchronous, active high),
//          bus (slave side of sobel_mac_pipe_if: taps in, window sums out).
//   A single enable adv = !out_valid || out_ready moves the whole pipe, so a
//   stalled output freezes every stage, the tap counter and the accumulator.
// -----------------------------------------------------------------------------
module sobel_mac_pipe
  import sobel_pkg::*;
#(
  parameter int A_W        = SOBEL_A_W,
  parameter int B_W        = SOBEL_B_W,
  parameter int MUL_STAGES = 2,
  parameter int TAPS       = SOBEL_TAPS,
  parameter int OUT_W      = SOBEL_OUT_W,
  parameter bit SAT        = 1'b1
) (
  input  logic            ap_clk,
  input  logic            ap_rst,
  sobel_mac_pipe_if.slave bus
);

  localparam int P_W   = A_W + B_W;
  localparam int ACC_W = P_W + clog2(TAPS);
  localparam int CNT_W = (TAPS > 1) ? clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  logic                    adv;
  logic                    in_fire;
  logic                    prod_valid;
  logic signed [P_W-1:0]   prod;

  logic [CNT_W-1:0]        tap_cnt_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  wide_t                   acc_wide;
  wide_t                   acc_sat;

  logic                    out_valid_reg;
  logic signed [OUT_W-1:0] dout_reg;
  logic signed [OUT_W-1:0] dout_next;
  logic                    out_ovf_reg;
  logic                    ovf_next;

  assign adv          = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = adv && !bus.acc_clr && !ap_rst;
  assign in_fire      = bus.in_valid && bus.in_ready;

  sobel_mac_mul_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .adv        (adv),
    .flush      (bus.acc_clr),
    .in_fire    (in_fire),
    .a          (bus.din_a),
    .b          (bus.din_b),
    .prod_valid (prod_valid),
    .prod       (prod)
  );

  // First product of a window replaces the accumulator instead of adding,
  // so the next window can start the cycle right after the last one closes.
  // Out-of-range detection is the same for both modes: the value differs
  // from its clamp exactly when the discarded bits are not a sign extension.
  always_comb begin
    acc_next = ACC_W'(prod);
    if (tap_cnt_reg != '0) acc_next = acc_reg + ACC_W'(prod);
    acc_wide  = wide_t'(acc_next);
    acc_sat   = sat_signed(acc_wide, OUT_W);
    ovf_next  = (acc_sat != acc_wide);
    dout_next = SAT ? acc_sat[OUT_W-1:0] : acc_wide[OUT_W-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tap_cnt_reg   <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      dout_reg      <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      if (out_valid_reg && bus.out_ready) out_valid_reg <= 1'b0;

      // Abort beats a window-completing product in the same cycle; the
      // already finished result in the output register is left alone.
      if (bus.acc_clr) begin
        tap_cnt_reg <= '0;
        acc_reg     <= '0;
      end else if (adv && prod_valid) begin
        acc_reg <= acc_next;
        if (tap_cnt_reg == LAST_TAP) begin
          tap_cnt_reg   <= '0;
          out_valid_reg <= 1'b1;
          dout_reg      <= dout_next;
          out_ovf_reg   <= ovf_next;
        end else begin
          tap_cnt_reg <= tap_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.dout      = dout_reg;
  assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_sobel_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_sobel_mac_pipe
//   Directed bench for sobel_mac_pipe: reset, Gx window and latency,
//   saturation / wrap, backpressure, abort, reset mid-window, random windows.
//   Inputs change 1 time unit after the rising edge; the handshake monitor
//   samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_sobel_mac_pipe;
  import sobel_pkg::*;

  localparam int MS = 2;
  localparam int NW = 1000;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 ap_clk = ~ap_clk;

  sobel_mac_pipe_if #(.A_W(11), .B_W(11), .OUT_W(20)) bus   ();
  sobel_mac_pipe_if #(.A_W(11), .B_W(11), .OUT_W(12)) bus_s ();
  sobel_mac_pipe_if #(.A_W(11), .B_W(11), .OUT_W(12)) bus_w ();

  sobel_mac_pipe #(
    .A_W(11), .B_W(11), .MUL_STAGES(MS), .TAPS(9), .OUT_W(20), .SAT(1'b1)
  ) dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));

  sobel_mac_pipe #(
    .A_W(11), .B_W(11), .MUL_STAGES(1), .TAPS(9), .OUT_W(12), .SAT(1'b1)
  ) dut_sat (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus_s));

  sobel_mac_pipe #(
    .A_W(11), .B_W(11), .MUL_STAGES(4), .TAPS(9), .OUT_W(12), .SAT(1'b0)
  ) dut_wrap (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus_w));

  logic signed [19:0] q_dout [$];
  logic               q_ovf  [$];
  longint             exp_q  [$];
  bit                 feed_done;

  // One line per output transfer of the main engine.
  always @(negedge ap_clk) begin
    if (!ap_rst && bus.out_valid && bus.out_ready) begin
      q_dout.push_back(bus.dout);
      q_ovf.push_back(bus.out_ovf);
      $display("out %0d: dout=%0d ovf=%0b", q_dout.size(), bus.dout, bus.out_ovf);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one tap and hold it until accepted; returns 1 unit after the edge.
  task automatic send_tap(input int a, input int b);
    int n;
    n = 0;
    bus.din_a    = 11'(a);
    bus.din_b    = 11'(b);
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 500) begin
      @(posedge ap_clk); #2;
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL send_tap_timeout: in_ready=%0b required=1", bus.in_ready);
    end
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int c;
    c = 0;
    while (q_dout.size() < n && c < 400) begin
      @(posedge ap_clk); #1;
      c++;
    end
    repeat (8) begin @(posedge ap_clk); #1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got=%0b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got=%0b exp=0", bus.out_valid); end
    total++; if (bus.dout !== 20'sd0) begin bad++; $display("FAIL rst_dout: got=%0d exp=0", bus.dout); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got=%0b exp=0", bus.out_ovf); end
    total++; if (bus_s.out_valid !== 1'b0 || bus_w.out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_sat_valid: got=%0b/%0b exp=0/0", bus_s.out_valid, bus_w.out_valid);
    end
    ap_rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got=%0b exp=1", bus.in_ready); end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_gx();
    int pix [9] = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    int n;
    q_dout.delete(); q_ovf.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_tap(pix[i], SOBEL_GX[i]);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge ap_clk); #1;
      n++;
    end
    total++; if (n != MS + 1) begin bad++; $display("FAIL gx_latency: got=%0d exp=%0d", n, MS + 1); end
    wait_outs(1);
    total++; if (q_dout.size() != 1) begin bad++; $display("FAIL gx_count: got=%0d exp=1", q_dout.size()); end
    total++; if (q_dout[0] !== 20'sd80) begin bad++; $display("FAIL gx_dout: got=%0d exp=80", q_dout[0]); end
    total++; if (q_ovf[0] !== 1'b0) begin bad++; $display("FAIL gx_ovf: got=%0b exp=0", q_ovf[0]); end
  endtask

  task automatic test_saturation();
    logic signed [11:0] ds, dw;
    logic               os, ow;
    bit                 got_s, got_w;
    got_s = 1'b0; got_w = 1'b0;
    ds = '0; dw = '0; os = 1'b0; ow = 1'b0;
    bus_s.din_a = 11'sd1023; bus_s.din_b = 11'sd1023; bus_s.in_valid = 1'b1;
    bus_w.din_a = 11'sd1023; bus_w.din_b = 11'sd1023; bus_w.in_valid = 1'b1;
    repeat (9) @(posedge ap_clk);
    #1;
    bus_s.in_valid = 1'b0;
    bus_w.in_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (bus_s.out_valid && !got_s) begin got_s = 1'b1; ds = bus_s.dout; os = bus_s.out_ovf; end
      if (bus_w.out_valid && !got_w) begin got_w = 1'b1; dw = bus_w.dout; ow = bus_w.out_ovf; end
      @(posedge ap_clk); #1;
    end
    total++; if (!got_s) begin bad++; $display("FAIL sat_seen: got=0 exp=1"); end
    total++; if (!got_w) begin bad++; $display("FAIL wrap_seen: got=0 exp=1"); end
    total++; if (ds !== 12'sd2047) begin bad++; $display("FAIL sat_dout: got=%0d exp=2047", ds); end
    total++; if (os !== 1'b1) begin bad++; $display("FAIL sat_ovf: got=%0b exp=1", os); end
    total++; if (dw !== 12'h809) begin bad++; $display("FAIL wrap_dout: got=%h exp=809", dw); end
    total++; if (ow !== 1'b1) begin bad++; $display("FAIL wrap_ovf: got=%0b exp=1", ow); end
  endtask

  task automatic test_back_to_back();
    q_dout.delete(); q_ovf.delete();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int w = 0; w < 2; w++)
          for (int k = 0; k < 9; k++) send_tap(k + 1, (w == 0) ? 1 : -2);
      end
      begin
        int n;
        n = 0;
        #2;
        while (!bus.out_valid && n < 300) begin
          @(posedge ap_clk); #3;
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got=%0b exp=0", i, bus.in_ready); end
          total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got=%0b exp=1", i, bus.out_valid); end
          total++; if (bus.dout !== 20'sd45) begin bad++; $display("FAIL stall_dout[%0d]: got=%0d exp=45", i, bus.dout); end
          if (i < 4) begin @(posedge ap_clk); #3; end
        end
        @(posedge ap_clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_outs(2);
    total++; if (q_dout.size() != 2) begin bad++; $display("FAIL b2b_count: got=%0d exp=2", q_dout.size()); end
    total++; if (q_dout[0] !== 20'sd45) begin bad++; $display("FAIL b2b_first: got=%0d exp=45", q_dout[0]); end
    total++; if (q_dout[1] !== -20'sd90) begin bad++; $display("FAIL b2b_second: got=%0d exp=-90", q_dout[1]); end
  endtask

  task automatic test_abort();
    q_dout.delete(); q_ovf.delete();
    for (int i = 0; i < 4; i++) send_tap(5, 7);
    bus.acc_clr = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready: got=%0b exp=0", bus.in_ready); end
    @(posedge ap_clk); #1;
    bus.acc_clr = 1'b0;
    for (int i = 0; i < 9; i++) send_tap(1, 1);
    wait_outs(1);
    total++; if (q_dout.size() != 1) begin bad++; $display("FAIL abort_count: got=%0d exp=1", q_dout.size()); end
    total++; if (q_dout[0] !== 20'sd9) begin bad++; $display("FAIL abort_dout: got=%0d exp=9", q_dout[0]); end
  endtask

  task automatic test_reset_mid();
    int n;
    q_dout.delete(); q_ovf.delete();
    // A finished window parked in the output register must be dropped by reset.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_tap(1, 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin @(posedge ap_clk); #1; n++; end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL park_valid: got=%0b exp=1", bus.out_valid); end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL park_rst_valid: got=%0b exp=0", bus.out_valid); end
    total++; if (bus.dout !== 20'sd0) begin bad++; $display("FAIL park_rst_dout: got=%0d exp=0", bus.dout); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_tap(3, 3);
    ap_rst       = 1'b1;
    bus.in_valid = 1'b1;
    bus.din_a    = 11'sd7;
    bus.din_b    = 11'sd7;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready: got=%0b exp=0", bus.in_ready); end
    @(posedge ap_clk); #1;
    ap_rst       = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got=%0b exp=0", bus.out_valid); end
    for (int i = 0; i < 9; i++) send_tap(-2, 3);
    wait_outs(1);
    total++; if (q_dout.size() != 1) begin bad++; $display("FAIL midrst_count: got=%0d exp=1", q_dout.size()); end
    total++; if (q_dout[0] !== -20'sd54) begin bad++; $display("FAIL midrst_dout: got=%0d exp=-54", q_dout[0]); end
  endtask

  task automatic test_random();
    q_dout.delete(); q_ovf.delete(); exp_q.delete();
    feed_done = 1'b0;
    fork
      begin
        for (int w = 0; w < NW; w++) begin
          longint s;
          s = 0;
          for (int t = 0; t < 9; t++) begin
            int a, b;
            if ((w % 2) == 1) begin
              a = int'($urandom_range(511)) - 256;
              b = int'($urandom_range(511)) - 256;
            end else begin
              a = int'($urandom_range(2047)) - 1024;
              b = int'($urandom_range(2047)) - 1024;
            end
            if ($urandom_range(3) == 0) begin @(posedge ap_clk); #1; end
            s += longint'(a) * longint'(b);
            send_tap(a, b);
          end
          exp_q.push_back(s);
        end
        feed_done = 1'b1;
      end
      begin
        int c;
        c = 0;
        while (!(feed_done && q_dout.size() >= NW) && c < 60000) begin
          @(posedge ap_clk); #1;
          bus.out_ready = ($urandom_range(3) != 0);
          c++;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_outs(NW);
    total++; if (q_dout.size() != NW) begin bad++; $display("FAIL rnd_count: got=%0d exp=%0d", q_dout.size(), NW); end
    for (int i = 0; i < NW && i < q_dout.size(); i++) begin
      longint             cl;
      logic signed [19:0] e;
      cl = exp_q[i];
      if (cl > 524287)  cl = 524287;
      if (cl < -524288) cl = -524288;
      e = 20'(cl);
      total++; if (q_dout[i] !== e) begin bad++; $display("FAIL rnd_dout[%0d]: got=%0d exp=%0d", i, q_dout[i], e); end
      total++; if (q_ovf[i] !== (cl != exp_q[i])) begin bad++; $display("FAIL rnd_ovf[%0d]: got=%0b exp=%0b", i, q_ovf[i], cl != exp_q[i]); end
    end
  endtask

  initial begin
    bus.acc_clr   = 1'b0; bus.in_valid   = 1'b0; bus.din_a   = '0; bus.din_b   = '0; bus.out_ready   = 1'b1;
    bus_s.acc_clr = 1'b0; bus_s.in_valid = 1'b0; bus_s.din_a = '0; bus_s.din_b = '0; bus_s.out_ready = 1'b1;
    bus_w.acc_clr = 1'b0; bus_w.in_valid = 1'b0; bus_w.din_a = '0; bus_w.din_b = '0; bus_w.out_ready = 1'b1;
    test_reset();
    test_gx();
    test_saturation();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
